// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//   Receive side of one HDMI TMDS channel. It takes 10-bit words from a 1:10
//   deserializer with unknown bit phase, finds symbol alignment by locking
//   onto runs of control tokens, then classifies each aligned symbol as a
//   control token, video byte, TERC4 nibble, guard band or decode error.
//
//   Pipeline: raw_q (word capture) -> symbol (aligned, 1 clk after raw_q)
//             -> decode outputs (registered, 2 clks after the capture edge).
//
// Parameters
//   CHANNEL     TMDS channel 0..2, selects guard-band codes
//   LOCK_COUNT  consecutive control tokens at one offset needed to lock
//   DWELL       cycles per offset while searching before slipping one bit
//   TIMEOUT     cycles without a control token before lock is dropped
//
// Ports
//   clk_pixel, reset (async, active-high)
//   tmds_raw[9:0]     deserialized word, bit 0 received first
//   island_period     current symbol lies inside a data island
//   symbol[9:0]       aligned symbol
//   locked, bit_offset[3:0]
//   ctrl_valid/ctrl[1:0], video_valid/video_data[7:0],
//   terc4_valid/terc4_data[3:0], guard_band, decode_error
//   disparity_error   only with TMDS_DECODER_DISPARITY_CHECK_EN defined
//
// Optional feature macro: TMDS_DECODER_DISPARITY_CHECK_EN
//   Adds a running-disparity monitor over video symbols.

module tmds_channel_decoder #(
    parameter int CHANNEL    = 0,
    parameter int LOCK_COUNT = 8,
    parameter int DWELL      = 1024,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] tmds_raw,
    input  logic       island_period,
    output logic [9:0] symbol,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic       ctrl_valid,
    output logic [1:0] ctrl,
    output logic       video_valid,
    output logic [7:0] video_data,
    output logic       terc4_valid,
    output logic [3:0] terc4_data,
    output logic       guard_band,
`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
    output logic       disparity_error,
`endif
    output logic       decode_error
);

    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int DW = (DWELL > 1)   ? $clog2(DWELL)   : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [RW-1:0] RUN_LAST   = RW'(LOCK_COUNT - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    localparam logic [9:0] VID_GB    = (CHANNEL == 1) ? 10'h133 : 10'h2CC;
    localparam logic [9:0] ISL_GB    = 10'h133;
    localparam bit         ISL_GB_EN = (CHANNEL != 0);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   run_q, run_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      offset_d;
    logic            slip_q, slip_d;
    logic [9:0]      raw_q;
    logic [29:0]     w_ext;
    logic [1:0]      gb_cnt;

    // ---------------------------------------------------------------
    // Alignment: 20-bit window, older word in the low half.
    // Zero padding keeps the variable part-select inside range.
    // ---------------------------------------------------------------
    assign w_ext = {10'b0, tmds_raw, raw_q};

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            raw_q  <= '0;
            symbol <= '0;
        end else begin
            raw_q  <= tmds_raw;
            symbol <= w_ext[bit_offset +: 10];
        end
    end

    // ---------------------------------------------------------------
    // Symbol classification (combinational on the aligned symbol)
    // ---------------------------------------------------------------
    logic       is_ctrl;
    logic [1:0] ctrl_code;
    logic       t_hit;
    logic [3:0] t_nib;
    logic       gb_hit;

    always_comb begin
        is_ctrl   = 1'b1;
        ctrl_code = 2'b00;
        case (symbol)
            10'h354: ctrl_code = 2'b00;
            10'h0AB: ctrl_code = 2'b01;
            10'h154: ctrl_code = 2'b10;
            10'h2AB: ctrl_code = 2'b11;
            default: is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        t_hit = 1'b1;
        t_nib = 4'h0;
        case (symbol)
            10'h29C: t_nib = 4'h0;
            10'h263: t_nib = 4'h1;
            10'h2E4: t_nib = 4'h2;
            10'h2E2: t_nib = 4'h3;
            10'h171: t_nib = 4'h4;
            10'h11E: t_nib = 4'h5;
            10'h18E: t_nib = 4'h6;
            10'h13C: t_nib = 4'h7;
            10'h2CC: t_nib = 4'h8;
            10'h139: t_nib = 4'h9;
            10'h19C: t_nib = 4'hA;
            10'h2C6: t_nib = 4'hB;
            10'h28E: t_nib = 4'hC;
            10'h271: t_nib = 4'hD;
            10'h163: t_nib = 4'hE;
            10'h2C3: t_nib = 4'hF;
            default: t_hit = 1'b0;
        endcase
    end

    assign gb_hit = island_period ? (ISL_GB_EN && symbol == ISL_GB)
                                  : (symbol == VID_GB);

    function automatic logic [7:0] video_dec(input logic [9:0] q);
        logic [7:0] b, d;
        b    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = b[0];
        for (int i = 1; i < 8; i++)
            d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        return d;
    endfunction

    // ---------------------------------------------------------------
    // Alignment FSM
    // ---------------------------------------------------------------
    logic [3:0] next_off;
    assign next_off = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        dwell_d  = dwell_q;
        tmo_d    = tmo_q;
        offset_d = bit_offset;
        slip_d   = 1'b0;
        case (state_q)
            SEARCH: begin
                // The symbol just after a slip was cut at the old offset,
                // so it never counts toward a run.
                if (!slip_q && is_ctrl && run_q == RUN_LAST) begin
                    state_d = LOCKED;
                    run_d   = '0;
                    dwell_d = '0;
                    tmo_d   = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    offset_d = next_off;
                    slip_d   = 1'b1;
                    run_d    = '0;
                    dwell_d  = '0;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                    run_d   = (!slip_q && is_ctrl) ? run_q + 1'b1 : '0;
                end
            end
            LOCKED: begin
                if (is_ctrl) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = SEARCH;
                    offset_d = next_off;
                    slip_d   = 1'b1;
                    tmo_d    = '0;
                    run_d    = '0;
                    dwell_d  = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            run_q      <= '0;
            dwell_q    <= '0;
            tmo_q      <= '0;
            bit_offset <= '0;
            slip_q     <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            dwell_q    <= dwell_d;
            tmo_q      <= tmo_d;
            bit_offset <= offset_d;
            slip_q     <= slip_d;
            locked     <= (state_d == LOCKED);
        end
    end

    // ---------------------------------------------------------------
    // Decode stage: one-hot classification, only while locked
    // ---------------------------------------------------------------
    logic dv_ctrl, dv_gb, dv_t, dv_err, dv_vid;

    always_comb begin
        dv_ctrl = 1'b0;
        dv_gb   = 1'b0;
        dv_t    = 1'b0;
        dv_err  = 1'b0;
        dv_vid  = 1'b0;
        if (state_q == LOCKED) begin
            if (is_ctrl)                    dv_ctrl = 1'b1;
            else if (gb_cnt != 2'd0 && gb_hit) dv_gb = 1'b1;
            else if (island_period) begin
                if (t_hit) dv_t   = 1'b1;
                else       dv_err = 1'b1;
            end else                        dv_vid  = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            gb_cnt       <= '0;
            ctrl_valid   <= 1'b0;
            ctrl         <= '0;
            video_valid  <= 1'b0;
            video_data   <= '0;
            terc4_valid  <= 1'b0;
            terc4_data   <= '0;
            guard_band   <= 1'b0;
            decode_error <= 1'b0;
        end else begin
            // Guard bands are only recognised in the two slots after a
            // control run.
            if (is_ctrl)             gb_cnt <= 2'd2;
            else if (gb_cnt != 2'd0) gb_cnt <= gb_cnt - 2'd1;

            ctrl_valid   <= dv_ctrl;
            video_valid  <= dv_vid;
            terc4_valid  <= dv_t;
            guard_band   <= dv_gb;
            decode_error <= dv_err;
            if (dv_ctrl) ctrl       <= ctrl_code;
            if (dv_vid)  video_data <= video_dec(symbol);
            if (dv_t)    terc4_data <= t_nib;
        end
    end

`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
    // Running disparity over video symbols: each symbol adds ones - zeros.
    logic signed [7:0] disp_acc;
    logic signed [7:0] disp_delta;
    logic signed [7:0] disp_sum;
    logic        [3:0] disp_ones;

    assign disp_ones  = 4'($countones(symbol));
    assign disp_delta = $signed({3'b0, disp_ones, 1'b0}) - 8'sd10;
    assign disp_sum   = disp_acc + disp_delta;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            disp_acc        <= '0;
            disparity_error <= 1'b0;
        end else begin
            disparity_error <= 1'b0;
            if (dv_ctrl) begin
                disp_acc <= '0;
            end else if (dv_vid) begin
                if (disp_sum > 8'sd20 || disp_sum < -8'sd20) begin
                    disparity_error <= 1'b1;
                    disp_acc        <= '0;
                end else begin
                    disp_acc <= disp_sum;
                end
            end
        end
    end
`endif

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the HDMI TMDS transmit path; one instance per TMDS channel.
- Input: 10-bit words from a 1:10 deserializer with arbitrary bit phase.
- Finds symbol alignment by locking onto control tokens and decodes each aligned symbol as one of: video 8b, control bits, TERC4 nibble, or guard band.
- Used for HDMI loopback self-test and capture.

Parameters:
- CHANNEL, 0 – TMDS channel index 0..2; selects the guard-band codes.
- LOCK_COUNT, 8 – consecutive control tokens at one offset required to lock.
- DWELL, 1024 – cycles spent at one offset in SEARCH before slipping.
- TIMEOUT, 4096 – cycles in LOCKED with no control token before lock is dropped.

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- tmds_raw  in  10  deserialized word; bit 0 is the first bit received
- island_period  in  1  high while the current symbol is inside a data island (from the channel-1/2 preamble tracker)
- symbol  out  10  aligned symbol
- locked  out  1  alignment achieved
- bit_offset  out  4  current slip offset, 0..9
- ctrl_valid  out  1  control token decoded
- ctrl  out  2  {c1,c0}
- video_valid  out  1  video symbol decoded
- video_data  out  8  decoded byte
- terc4_valid  out  1  TERC4 symbol decoded
- terc4_data  out  4  decoded nibble
- guard_band  out  1  guard-band symbol seen
- decode_error  out  1  symbol not legal in the current period

Behaviour:
- Reset: all outputs 0, state SEARCH, bit_offset 0, all counters 0, raw_q 0. Reset asserted mid-operation returns immediately to this state.

Alignment:
- raw_q registers tmds_raw.
- Window w = {tmds_raw, raw_q} (20 bits).
- symbol <= w[bit_offset+9 : bit_offset], registered. Latency is 1 clock.

Token tables (10-bit codes):
- Control tokens: 0x354→00, 0x0AB→01, 0x154→10, 0x2AB→11.
- TERC4: 0x29C,0x263,0x2E4,0x2E2,0x171,0x11E,0x18E,0x13C,0x2CC,0x139,0x19C,0x2C6,0x28E,0x271,0x163,0x2C3 → 0..F.
- Video guard band: 0x2CC for CHANNEL 0 and 2; 0x133 for CHANNEL 1.
- Island guard band: 0x133 for CHANNEL 1 and 2 only.

FSM, evaluated on symbol:
- SEARCH:
  - Control token: run_cnt++; any other symbol clears run_cnt.
  - run_cnt reaching LOCK_COUNT → LOCKED; locked=1 on the following edge.
  - dwell_cnt reaching DWELL-1 without lock → bit_offset = (bit_offset==9) ? 0 : bit_offset+1; run_cnt and dwell_cnt clear.
  - While bit_offset is changing, symbol output is valid only from the next cycle. Decode outputs stay 0 in SEARCH.
- LOCKED:
  - tmo_cnt clears on every control token, otherwise increments.
  - tmo_cnt reaching TIMEOUT-1 → SEARCH, locked=0, bit_offset increments (wrapping 9→0), counters clear.

Decode:
- Stage 2 registers the decode, so decoded outputs are 2 clocks after the tmds_raw edge.
- At most one of ctrl_valid / video_valid / terc4_valid / guard_band / decode_error is high per cycle.
- Priority order:
  1. Control token → ctrl_valid.
  2. First two non-control symbols after a control run, if they equal the applicable guard code (island code when island_period=1, video code otherwise) → guard_band.
  3. island_period=1: TERC4 match → terc4_valid; otherwise decode_error.
  4. Otherwise video: b = q[9] ? ~q[7:0] : q[7:0]; d[0]=b[0]; d[i] = q[8] ? b[i]^b[i-1] : ~(b[i]^b[i-1]); video_valid.
- Valid/error outputs are single-cycle pulses; data outputs hold their last value.

Optional Feature:
- Macro: TMDS_DECODER_DISPARITY_CHECK_EN.
- Defined:
  - Adds output disparity_error (1 bit).
  - 8-bit signed accumulator adds (ones − zeros) of every video symbol; it clears on each control token.
  - disparity_error pulses, and the accumulator clears, when |acc| > 20.
- Undefined: no port and no logic.

Test Plan:
- Aligned stream of 0x354 ×20 → locked=1 after the 8th token is registered, bit_offset=0; ctrl_valid=1 with ctrl=00.
- Same stream rotated by 3 bits (1024 cycles of 0x354 at each trial) → locked=1 with bit_offset=3 during the 4th dwell period; 0x0AB decodes to ctrl=01.
- Locked, island_period=0: 0x100 → video_data=0x00; 0x200 → video_data=0xFF. Each has video_valid=1 exactly 2 clocks after input.
- Locked, island_period=1, after a control run: 0x133 (CHANNEL=1) → guard_band. Then 0x29C → terc4_data=0; 0x2C3 → terc4_data=F; 0x3FF → decode_error=1.
- Locked, then 4096 cycles of 0x100 with no control tokens → locked=0 and bit_offset=1 on the TIMEOUT cycle; decode outputs stay 0 afterwards.
- reset pulsed mid-LOCKED while decoding video → all outputs 0 asynchronously; re-lock from bit_offset 0 after 8 tokens.
